// File: rtl/weight_opt_pkg.sv
// weight_opt_pkg: shared widths, weight type and sequencer state encoding.
//   WW         - weight/delta width in bits
//   LANES      - weights per memory word (datapath lane count)
//   weight_t   - one signed weight
//   wu_state_e - weight_update_ctrl FSM states
package weight_opt_pkg;
    localparam int WW    = 10;
    localparam int LANES = 5;
    typedef logic signed [WW-1:0] weight_t;
    typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, FIN} wu_state_e;
endpackage

// File: rtl/weight_update_ctrl.sv
// weight_update_ctrl: walks the weight RAM one group at a time, feeding each
// group to the external WeightUpdate datapath and writing its result back.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   start, abort                - begin / terminate a pass
//   delta_in, sign_in           - update magnitude/direction, latched on start
//   busy, done, aborted         - status; done/aborted are one-cycle pulses
//   mem_addr, mem_rd_en         - RAM read (data valid the following cycle)
//   mem_rd_data                 - packed read data, lane 0 in LSBs
//   mem_wr_en, mem_wr_data      - RAM write back
//   dp_weight, dp_delta, dp_sign - operands presented to the datapath
//   dp_weight_new               - datapath result
module weight_update_ctrl
    import weight_opt_pkg::*;
#(
    parameter int WW         = weight_opt_pkg::WW,
    parameter int LANES      = weight_opt_pkg::LANES,
    parameter int NUM_GROUPS = 8,
    localparam int AW        = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [WW-1:0]       delta_in,
    input  logic                sign_in,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_rd_en,
    input  logic [LANES*WW-1:0] mem_rd_data,
    output logic                mem_wr_en,
    output logic [LANES*WW-1:0] mem_wr_data,
    output logic [LANES*WW-1:0] dp_weight,
    output logic [WW-1:0]       dp_delta,
    output logic                dp_sign,
    input  logic [LANES*WW-1:0] dp_weight_new
);
    wu_state_e             state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [LANES*WW-1:0]   wgt_q, wgt_d;
    logic [WW-1:0]         delta_q, delta_d;
    logic                  sign_q, sign_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  abt_q, abt_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;

    // Strobes and pulses are decided on the transition so every output
    // comes straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wgt_d   = wgt_q;
        delta_d = delta_q;
        sign_d  = sign_q;
        done_d  = 1'b0;
        abt_d   = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                delta_d = delta_in;
                sign_d  = sign_in;
                cnt_d   = '0;
                state_d = READ;
                rd_d    = 1'b1;
            end
            READ: begin
                state_d = abort ? IDLE : LATCH;
                abt_d   = abort;
            end
            LATCH: if (abort) begin
                state_d = IDLE;
                abt_d   = 1'b1;
            end else begin
                wgt_d   = mem_rd_data;
                state_d = WRITE;
                wr_d    = 1'b1;
            end
            // The write strobe is already high this cycle, so abort only
            // stops the walk after the current group lands.
            WRITE: if (abort) begin
                state_d = IDLE;
                abt_d   = 1'b1;
            end else if (cnt_q == AW'(NUM_GROUPS - 1)) begin
                state_d = FIN;
                done_d  = 1'b1;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = READ;
                rd_d    = 1'b1;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wgt_q   <= '0;
            delta_q <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abt_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wgt_q   <= wgt_d;
            delta_q <= delta_d;
            sign_q  <= sign_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abt_q   <= abt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = abt_q;
    assign mem_addr    = cnt_q;
    assign mem_rd_en   = rd_q;
    assign mem_wr_en   = wr_q;
    assign mem_wr_data = dp_weight_new;
    assign dp_weight   = wgt_q;
    assign dp_delta    = delta_q;
    assign dp_sign     = sign_q;
endmodule
